// File: rtl/text_term_pkg.sv
// Shared definitions for the text terminal: writer FSM states, control
// character codes and the printable range.
package text_term_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_CLR_LINE,
    ST_CLR_ALL
  } state_e;

  localparam logic [7:0] CHAR_BS       = 8'h08;
  localparam logic [7:0] CHAR_LF       = 8'h0A;
  localparam logic [7:0] CHAR_FF       = 8'h0C;
  localparam logic [7:0] CHAR_CR       = 8'h0D;
  localparam logic [7:0] CHAR_SPACE    = 8'h20;
  localparam logic [7:0] CHAR_PRINT_LO = 8'h20;
  localparam logic [7:0] CHAR_PRINT_HI = 8'h7E;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= CHAR_PRINT_LO) && (c <= CHAR_PRINT_HI);
  endfunction

endpackage

// File: rtl/text_cursor_writer_if.sv
// Byte-in handshake from the UART receiver plus the character RAM write port.
interface text_cursor_writer_if #(
  parameter int ROW_W = 2,
  parameter int COL_W = 5
);
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic             ram_we;
  logic [ROW_W-1:0] ram_row;
  logic [COL_W-1:0] ram_col;
  logic [7:0]       ram_data;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, ram_we, ram_row, ram_col, ram_data
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, ram_we, ram_row, ram_col, ram_data
  );
endinterface

// File: rtl/text_cursor_writer_cursor_step.sv
// Combinational cursor arithmetic: next cell forward (with wrap flag) and
// previous cell backward, saturating at the top-left corner.
module cursor_step #(
  parameter int COLS  = 32,
  parameter int ROWS  = 4,
  parameter int COL_W = $clog2(COLS),
  parameter int ROW_W = $clog2(ROWS)
) (
  input  logic [ROW_W-1:0] row,
  input  logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] adv_row,
  output logic [COL_W-1:0] adv_col,
  output logic             adv_wrap,
  output logic [ROW_W-1:0] back_row,
  output logic [COL_W-1:0] back_col
);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  always_comb begin
    adv_wrap = (col == COL_LAST);
    adv_col  = adv_wrap ? '0 : col + COL_W'(1);
    adv_row  = row;
    if (adv_wrap) begin
      adv_row = (row == ROW_LAST) ? '0 : row + ROW_W'(1);
    end

    back_row = row;
    back_col = col;
    if (col != '0) begin
      back_col = col - COL_W'(1);
    end else if (row != '0) begin
      back_row = row - ROW_W'(1);
      back_col = COL_LAST;
    end
  end
endmodule

// File: rtl/text_cursor_writer.sv
// Character-cell writer: turns received bytes into text RAM writes at the
// cursor, handling CR/LF/BS/FF, row wrap and optional new-line blanking.
module text_cursor_writer
  import text_term_pkg::*;
#(
  parameter int COLS       = 32,
  parameter int ROWS       = 4,
  parameter int LINE_CLEAR = 1,
  parameter int COL_W      = $clog2(COLS),
  parameter int ROW_W      = $clog2(ROWS)
) (
  input  logic                 clk,
  input  logic                 reset,
  text_cursor_writer_if.slave  bus,
  output logic [ROW_W-1:0]     cur_row,
  output logic [COL_W-1:0]     cur_col,
  output logic                 overrun
);
  localparam int               FILL_W   = ROW_W + COL_W;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic             LC       = (LINE_CLEAR != 0);

  state_e            state_q, state_d;
  logic [ROW_W-1:0]  cur_row_q, ram_row_q;
  logic [COL_W-1:0]  cur_col_q, ram_col_q;
  logic [7:0]        ram_data_q;
  logic              ram_we_q, overrun_q, clr_pend_q;
  logic [FILL_W-1:0] fill_q;

  logic [ROW_W-1:0]  adv_row, back_row, lf_row;
  logic [COL_W-1:0]  adv_col, back_col;
  logic              adv_wrap, accept, line_last, all_last;
  logic [7:0]        rx;

  cursor_step #(
    .COLS  (COLS),
    .ROWS  (ROWS),
    .COL_W (COL_W),
    .ROW_W (ROW_W)
  ) u_step (
    .row      (cur_row_q),
    .col      (cur_col_q),
    .adv_row  (adv_row),
    .adv_col  (adv_col),
    .adv_wrap (adv_wrap),
    .back_row (back_row),
    .back_col (back_col)
  );

  assign rx        = bus.rx_data;
  assign accept    = (state_q == ST_IDLE) && bus.rx_valid;
  assign lf_row    = cur_row_q + ROW_W'(1);
  assign line_last = (fill_q[COL_W-1:0] == COL_LAST);
  assign all_last  = &fill_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_printable(rx) || rx == CHAR_BS) state_d = ST_WRITE;
          else if (rx == CHAR_FF)                state_d = ST_CLR_ALL;
          else if (rx == CHAR_LF && LC)          state_d = ST_CLR_LINE;
        end
      end
      ST_WRITE:    state_d = clr_pend_q ? ST_CLR_LINE : ST_IDLE;
      ST_CLR_LINE: if (line_last) state_d = ST_IDLE;
      ST_CLR_ALL:  if (all_last)  state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // RAM outputs are loaded on the edge that enters each writing cycle, so a
  // clear following a WRITE starts on the very next cycle without a gap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_row_q  <= '0;
      cur_col_q  <= '0;
      ram_we_q   <= 1'b0;
      ram_row_q  <= '0;
      ram_col_q  <= '0;
      ram_data_q <= '0;
      overrun_q  <= 1'b0;
      clr_pend_q <= 1'b0;
      fill_q     <= '0;
    end else begin
      if (bus.rx_valid && state_q != ST_IDLE) overrun_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          ram_we_q <= 1'b0;
          if (accept) begin
            if (is_printable(rx)) begin
              ram_we_q   <= 1'b1;
              ram_row_q  <= cur_row_q;
              ram_col_q  <= cur_col_q;
              ram_data_q <= rx;
              cur_row_q  <= adv_row;
              cur_col_q  <= adv_col;
              clr_pend_q <= adv_wrap & LC;
            end else if (rx == CHAR_BS) begin
              ram_we_q   <= 1'b1;
              ram_row_q  <= back_row;
              ram_col_q  <= back_col;
              ram_data_q <= CHAR_SPACE;
              cur_row_q  <= back_row;
              cur_col_q  <= back_col;
              clr_pend_q <= 1'b0;
            end else if (rx == CHAR_CR) begin
              cur_col_q <= '0;
            end else if (rx == CHAR_LF) begin
              cur_row_q <= lf_row;
              cur_col_q <= '0;
              if (LC) begin
                ram_we_q   <= 1'b1;
                ram_row_q  <= lf_row;
                ram_col_q  <= '0;
                ram_data_q <= CHAR_SPACE;
                fill_q     <= {lf_row, {COL_W{1'b0}}};
              end
            end else if (rx == CHAR_FF) begin
              ram_we_q   <= 1'b1;
              ram_row_q  <= '0;
              ram_col_q  <= '0;
              ram_data_q <= CHAR_SPACE;
              fill_q     <= '0;
            end
          end
        end
        ST_WRITE: begin
          if (clr_pend_q) begin
            ram_we_q   <= 1'b1;
            ram_row_q  <= cur_row_q;
            ram_col_q  <= '0;
            ram_data_q <= CHAR_SPACE;
            fill_q     <= {cur_row_q, {COL_W{1'b0}}};
            clr_pend_q <= 1'b0;
          end else begin
            ram_we_q <= 1'b0;
          end
        end
        ST_CLR_LINE: begin
          if (line_last) begin
            ram_we_q <= 1'b0;
          end else begin
            fill_q    <= fill_q + FILL_W'(1);
            ram_col_q <= fill_q[COL_W-1:0] + COL_W'(1);
          end
        end
        ST_CLR_ALL: begin
          if (all_last) begin
            ram_we_q  <= 1'b0;
            cur_row_q <= '0;
            cur_col_q <= '0;
          end else begin
            fill_q                 <= fill_q + FILL_W'(1);
            {ram_row_q, ram_col_q} <= fill_q + FILL_W'(1);
          end
        end
        default: ram_we_q <= 1'b0;
      endcase
    end
  end

  assign bus.rx_ready = (state_q == ST_IDLE);
  assign bus.ram_we   = ram_we_q;
  assign bus.ram_row  = ram_row_q;
  assign bus.ram_col  = ram_col_q;
  assign bus.ram_data = ram_data_q;
  assign cur_row      = cur_row_q;
  assign cur_col      = cur_col_q;
  assign overrun      = overrun_q;
endmodule

// File: doc/text_cursor_writer.md
# text_cursor_writer

Parametrised character-cell writer between the UART receiver and the text-mode dual-port RAM that the VGA text generator reads. Accepts one received byte per handshake and writes printable characters at the cursor. Interprets CR, LF, BS and FF, with row wrap and optional clearing of a new line. Drives the RAM write port and exposes the cursor position for the seven-segment debug display.

## Interface
Parameters:
- `COLS`, 32: columns per screen; power of two, at least 2.
- `ROWS`, 4: rows per screen; power of two, at least 2.
- `LINE_CLEAR`, 1: when 1, a row is blanked (0x20) each time the cursor enters it by wrap or LF.
- `COL_W`, $clog2(COLS): column address width.
- `ROW_W`, $clog2(ROWS): row address width.

Ports:
- `clk` in 1: 100 MHz system clock.
- `reset` in 1: asynchronous, active-low reset.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: byte strobe; accepted when `rx_ready`=1.
- `rx_ready` out 1: high only in IDLE.
- `ram_we` out 1: one-cycle write strobe to the RAM.
- `ram_row` out ROW_W: write row.
- `ram_col` out COL_W: write column.
- `ram_data` out 8: write data.
- `cur_row` out ROW_W: cursor row.
- `cur_col` out COL_W: cursor column.
- `overrun` out 1: sticky; set when `rx_valid`=1 while `rx_ready`=0; cleared only by reset.

## Operation
- States: IDLE, WRITE, CLR_LINE, CLR_ALL.
- Reset values: state IDLE, cursor (0,0), `ram_we`=0, `ram_row`/`ram_col`=0, `ram_data`=0x00, `overrun`=0, `rx_ready`=1.
- Handshake in IDLE: the byte is accepted on the edge where `rx_valid`=1 and the state is IDLE. A byte offered outside IDLE is dropped, not queued, and sets `overrun`.
- Printable byte (0x20–0x7E) → WRITE:
  - Write the byte at the cursor.
  - Advance the column. At `COLS-1`, the column goes to 0 and the row advances modulo `ROWS`.
  - On a row change with `LINE_CLEAR`=1, go WRITE→CLR_LINE; otherwise WRITE→IDLE.
- CR (0x0D): column ← 0; no write; stays in IDLE.
- LF (0x0A): column ← 0, row ← (row+1) mod `ROWS`. With `LINE_CLEAR`=1 go to CLR_LINE; otherwise stay in IDLE.
- BS (0x08):
  - Step the cursor back one cell; from column 0 it goes to column `COLS-1` of the previous row.
  - At (0,0) the cursor does not move.
  - Then WRITE 0x20 at the new position; the cursor does not advance after this write.
- FF (0x0C): go to CLR_ALL; cursor ← (0,0) when CLR_ALL finishes.
- All other bytes, including 0x7F and ≥0x80: ignored; stay in IDLE; no write.
- CLR_LINE: writes 0x20 to columns 0..`COLS-1` of the cursor row, one per cycle, ascending; then IDLE.
- CLR_ALL: writes 0x20 to every cell in row-major order, starting at (0,0); then IDLE.
- Width rules:
  - The row wraps naturally by truncation to `ROW_W`.
  - The column compare is against `COLS-1`.
  - The fill counter is `ROW_W+COL_W` bits.

## Timing
- Accept at edge N. The registered outputs `ram_we`, `ram_row`, `ram_col` and `ram_data` are valid during cycle N+1, and the cursor update is visible in cycle N+1.
- Printable/BS without a row change: `rx_ready` low during N+1 and high again at N+2. Throughput is 1 byte per 2 cycles.
- CR, ignored bytes, and LF with `LINE_CLEAR`=0: no write; `rx_ready` stays high.
- CLR_LINE: exactly `COLS` consecutive `ram_we` cycles. When entered after a printable byte it starts immediately after the WRITE cycle.
- CLR_ALL: exactly `ROWS*COLS` consecutive `ram_we` cycles.
- `ram_we` is never asserted in IDLE.
- Reset asserted mid-clear: the clear is abandoned immediately, all reset values apply, and no further writes occur.

## Structure
- Shared package `text_term_pkg` holds:
  - the state encoding;
  - the character constants CHAR_BS, CHAR_LF, CHAR_FF, CHAR_CR and CHAR_SPACE;
  - the printable bounds 0x20/0x7E.
- One sub-module: `cursor_step`, a combinational next-position function (advance/back, with wrap flag) parametrised by `COLS`/`ROWS`.
- Everything else is in one always_ff block plus output decode.

## Test plan
- Reset, then bytes "A","B" (0x41, 0x42) spaced 4 cycles apart → writes (0,0)=0x41 and (0,1)=0x42; cursor (0,2); `overrun`=0.
- Cursor at (0,31), byte 0x5A with `LINE_CLEAR`=1 → write (0,31)=0x5A, then 32 writes of 0x20 to row 1, columns 0..31; cursor (1,0); `rx_ready` low for 33 cycles.
- Cursor at (3,5), LF → row 0 cleared; cursor (0,0). Same with `LINE_CLEAR`=0 → no writes and `rx_ready` never drops.
- BS at (2,0) → write (1,31)=0x20; cursor (1,31). BS at (0,0) → write (0,0)=0x20; cursor stays (0,0).
- FF → 128 consecutive writes of 0x20, from (0,0) to (3,31); cursor (0,0). Reset asserted after 50 of these writes → `ram_we` drops immediately, and all reset values apply.
- Two `rx_valid` strobes on consecutive cycles → first byte written, second dropped, `overrun`=1 and still 1 after further traffic.
